// File: rtl/pc_sequencer.sv
// Program-counter controller: IDLE/RUN/DONE/FAULT flow, relative jump/branch via offset LUT.
// Optional performance counters are enabled by defining PC_SEQ_PERF_CNT_EN.
module pc_sequencer #(
  parameter int PC_W     = 10,
  parameter int PROG_LEN = 1023
) (
  input  logic            CLK,
  input  logic            reset,
  input  logic            start,
  input  logic [PC_W-1:0] start_addr,
  input  logic            halt_req,
  input  logic            stall,
  input  logic            jmp_en,
  input  logic            brz_en,
  input  logic            zero_flag,
  input  logic [4:0]      lut_sel,
  output logic [4:0]      lut_ptr,
  input  logic [7:0]      lut_dout,
  output logic [PC_W-1:0] pc,
  output logic            fetch_en,
  output logic            busy,
  output logic            done,
  output logic            fault
`ifdef PC_SEQ_PERF_CNT_EN
  ,
  output logic [15:0]     instr_cnt,
  output logic [15:0]     taken_cnt
`endif
);

  localparam int W1 = PC_W + 1;
  localparam logic [PC_W:0] LIM = W1'(PROG_LEN);

  typedef enum logic [1:0] {IDLE, RUN, DONE, FAULT} state_t;

  state_t            state, state_nxt;
  logic [PC_W-1:0]   pc_nxt;
  logic              taken;
  logic signed [PC_W:0] off, sum;
  logic              sum_bad, start_bad;

  // Sum is one bit wider than pc so negative and overflowing targets are both visible.
  always_comb begin
    taken     = jmp_en | (brz_en & zero_flag);
    off       = taken ? $signed({{(W1-8){lut_dout[7]}}, lut_dout}) : $signed(W1'(1));
    sum       = $signed({1'b0, pc}) + off;
    sum_bad   = sum[PC_W] | ($unsigned(sum) >= LIM);
    start_bad = ({1'b0, start_addr} >= LIM);
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    case (state)
      RUN: begin
        if (!stall) begin
          if (halt_req)     state_nxt = DONE;
          else if (sum_bad) state_nxt = FAULT;
          else              pc_nxt    = sum[PC_W-1:0];
        end
      end
      default: begin
        if (start) begin
          if (start_bad) begin
            state_nxt = FAULT;
            pc_nxt    = '0;
          end else begin
            state_nxt = RUN;
            pc_nxt    = start_addr;
          end
        end
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state <= IDLE;
      pc    <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
    end
  end

  always_comb begin
    busy     = (state == RUN);
    fetch_en = busy & ~stall;
    done     = (state == DONE) | (state == FAULT);
    fault    = (state == FAULT);
    lut_ptr  = (busy & (jmp_en | brz_en)) ? lut_sel : 5'd0;
  end

`ifdef PC_SEQ_PERF_CNT_EN
  logic start_acc;
  assign start_acc = start & (state != RUN);

  always_ff @(posedge CLK) begin
    if (reset || start_acc) begin
      instr_cnt <= '0;
      taken_cnt <= '0;
    end else begin
      if (fetch_en && instr_cnt != 16'hFFFF)
        instr_cnt <= instr_cnt + 16'd1;
      if (fetch_en && !halt_req && taken && taken_cnt != 16'hFFFF)
        taken_cnt <= taken_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed + random bench for pc_sequencer against an integer-level behavioural model.
module tb_pc_sequencer;
  localparam int PC_W = 10;
  localparam int PROG_LEN = 1023;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic reset, start, halt_req, stall, jmp_en, brz_en, zero_flag;
  logic [PC_W-1:0] start_addr;
  logic [4:0] lut_sel, lut_ptr;
  logic [7:0] lut_dout;
  logic [PC_W-1:0] pc;
  logic fetch_en, busy, done, fault;
`ifdef PC_SEQ_PERF_CNT_EN
  logic [15:0] instr_cnt, taken_cnt;
`endif

  logic signed [7:0] lut [32];
  assign lut_dout = lut[lut_ptr];

  pc_sequencer #(.PC_W(PC_W), .PROG_LEN(PROG_LEN)) dut (
    .CLK(CLK), .reset(reset), .start(start), .start_addr(start_addr),
    .halt_req(halt_req), .stall(stall), .jmp_en(jmp_en), .brz_en(brz_en),
    .zero_flag(zero_flag), .lut_sel(lut_sel), .lut_ptr(lut_ptr),
    .lut_dout(lut_dout), .pc(pc), .fetch_en(fetch_en), .busy(busy),
    .done(done), .fault(fault)
`ifdef PC_SEQ_PERF_CNT_EN
    , .instr_cnt(instr_cnt), .taken_cnt(taken_cnt)
`endif
  );

  int total = 0;
  int bad = 0;

  // Model: pc as plain integer, run/done/fault flags, counters as integers.
  int m_pc = 0, m_run = 0, m_done = 0, m_fault = 0;
  int m_icnt = 0, m_tcnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input int exp);
    total++;
    assert (obs === 32'(exp)) else begin
      bad++;
      $error("FAIL %s got=%0d want=%0d", tag, obs, exp);
    end
  endtask

  task automatic clr_in();
    reset = 0; start = 0; start_addr = '0; halt_req = 0; stall = 0;
    jmp_en = 0; brz_en = 0; zero_flag = 0; lut_sel = '0;
  endtask

  task automatic cycle();
    int nxt;
    int tk;
    @(negedge CLK);
    chk("pc", 32'(pc), m_pc);
    chk("busy", 32'(busy), m_run);
    chk("done", 32'(done), m_done);
    chk("fault", 32'(fault), m_fault);
    chk("fetch_en", 32'(fetch_en), (m_run != 0 && !stall) ? 1 : 0);
    chk("lut_ptr", 32'(lut_ptr), (m_run != 0 && (jmp_en || brz_en)) ? int'(lut_sel) : 0);
`ifdef PC_SEQ_PERF_CNT_EN
    chk("instr_cnt", 32'(instr_cnt), m_icnt);
    chk("taken_cnt", 32'(taken_cnt), m_tcnt);
`endif
    if (reset) begin
      m_pc = 0; m_run = 0; m_done = 0; m_fault = 0; m_icnt = 0; m_tcnt = 0;
    end else if (m_run == 0) begin
      if (start) begin
        m_icnt = 0; m_tcnt = 0;
        if (int'(start_addr) >= PROG_LEN) begin
          m_pc = 0; m_run = 0; m_done = 1; m_fault = 1;
        end else begin
          m_pc = int'(start_addr); m_run = 1; m_done = 0; m_fault = 0;
        end
      end
    end else if (!stall) begin
      if (m_icnt < 65535) m_icnt++;
      if (halt_req) begin
        m_run = 0; m_done = 1;
      end else begin
        tk = (jmp_en || (brz_en && zero_flag)) ? 1 : 0;
        nxt = tk ? m_pc + int'(lut[lut_sel]) : m_pc + 1;
        if (tk != 0 && m_tcnt < 65535) m_tcnt++;
        if (nxt < 0 || nxt >= PROG_LEN) begin
          m_run = 0; m_done = 1; m_fault = 1;
        end else begin
          m_pc = nxt;
        end
      end
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic jmp(input int sel);
    clr_in(); jmp_en = 1; lut_sel = 5'(sel); cycle();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) lut[i] = 8'sd0;
    lut[1] = -8'sd12; lut[2] = 8'sd6;   lut[3] = 8'sd12;  lut[4] = 8'sd12;
    lut[5] = 8'sd4;   lut[6] = -8'sd12; lut[7] = -8'sd1;  lut[8] = -8'sd39;
    lut[9] = -8'sd18; lut[10] = 8'sd1;  lut[11] = 8'sd127; lut[12] = -8'sd128;
    clr_in();
    @(posedge CLK); #1;

    reset = 1; cycle(); cycle();
    chk("rst_pc", 32'(pc), 0);
    chk("rst_busy", 32'(busy), 0);
    clr_in(); start = 1; start_addr = 10'd5; cycle();
    chk("start_pc", 32'(pc), 5);
    chk("start_busy", 32'(busy), 1);
    clr_in();
    chk("start_fetch", 32'(fetch_en), 1);
    cycle(); cycle(); cycle();
    chk("seq_pc", 32'(pc), 8);

    jmp(3); chk("to20", 32'(pc), 20);
    clr_in(); jmp_en = 1; lut_sel = 5'd1;
    #1 chk("lut_ptr1", 32'(lut_ptr), 1);
    cycle(); chk("jmp_neg", 32'(pc), 8);
    jmp(3); jmp(2); chk("jmp_pos", 32'(pc), 26);
    jmp(5); chk("to30", 32'(pc), 30);
    clr_in(); brz_en = 1; zero_flag = 1; lut_sel = 5'd4; cycle();
    chk("brz_taken", 32'(pc), 42);
    jmp(6);
    clr_in(); brz_en = 1; zero_flag = 0; lut_sel = 5'd4; cycle();
    chk("brz_not", 32'(pc), 31);
    jmp(7);
    clr_in(); brz_en = 1; jmp_en = 1; zero_flag = 0; lut_sel = 5'd4; cycle();
    chk("jmp_brz", 32'(pc), 42);
    jmp(8); chk("to3", 32'(pc), 3);
    jmp(0); chk("self_loop", 32'(pc), 3);
    chk("self_loop_f", 32'(fault), 0);
    jmp(9);
    chk("neg_fault", 32'(fault), 1);
    chk("neg_done", 32'(done), 1);
    chk("neg_pc", 32'(pc), 3);
    clr_in(); start = 1; start_addr = '0; cycle();
    chk("restart_f", 32'(fault), 0);
    chk("restart_pc", 32'(pc), 0);
    chk("restart_busy", 32'(busy), 1);

    for (int i = 0; i < 4; i++) begin
      clr_in(); stall = 1; jmp_en = 1; lut_sel = 5'd3; start = 1; cycle();
    end
    chk("stall_pc", 32'(pc), 0);
    clr_in(); halt_req = 1; jmp_en = 1; lut_sel = 5'd3; cycle();
    chk("halt_done", 32'(done), 1);
    chk("halt_busy", 32'(busy), 0);
    chk("halt_pc", 32'(pc), 0);
    clr_in(); cycle(); cycle();

    clr_in(); start = 1; start_addr = 10'd1020; cycle();
    clr_in(); cycle(); cycle();
    chk("top_pc", 32'(pc), 1022);
    cycle();
    chk("top_fault", 32'(fault), 1);
    chk("top_pc_held", 32'(pc), 1022);
    clr_in(); start = 1; start_addr = 10'd1023; cycle();
    chk("bad_start_f", 32'(fault), 1);
    chk("bad_start_pc", 32'(pc), 0);
    clr_in(); start = 1; start_addr = 10'd1000; cycle();
    jmp(11); chk("ovf_fault", 32'(fault), 1);
    clr_in(); start = 1; start_addr = 10'd100; cycle();
    clr_in(); stall = 1; jmp_en = 1; cycle();
    reset = 1; stall = 1; jmp_en = 1; cycle();
    chk("rst_stall_pc", 32'(pc), 0);
    chk("rst_stall_busy", 32'(busy), 0);

`ifdef PC_SEQ_PERF_CNT_EN
    clr_in(); start = 1; start_addr = 10'd50; cycle();
    for (int i = 0; i < 10; i++) begin
      clr_in();
      if (i == 2 || i == 5 || i == 8) begin jmp_en = 1; lut_sel = 5'd10; end
      cycle();
    end
    chk("icnt10", 32'(instr_cnt), 10);
    chk("tcnt3", 32'(taken_cnt), 3);
    for (int i = 0; i < 70000; i++) jmp(0);
    chk("icnt_sat", 32'(instr_cnt), 65535);
    chk("tcnt_sat", 32'(taken_cnt), 65535);
`endif

    for (int i = 1; i < 32; i++) lut[i] = 8'($urandom_range(0, 60)) - 8'sd30;
    clr_in(); reset = 1; cycle();
    for (int i = 0; i < 600; i++) begin
      clr_in();
      reset      = ($urandom_range(0, 99) == 0);
      start      = ($urandom_range(0, 7) == 0);
      start_addr = ($urandom_range(0, 15) == 0) ? 10'd1023 : 10'($urandom_range(0, 1022));
      halt_req   = ($urandom_range(0, 29) == 0);
      stall      = ($urandom_range(0, 3) == 0);
      jmp_en     = ($urandom_range(0, 3) == 0);
      brz_en     = ($urandom_range(0, 3) == 0);
      zero_flag  = 1'($urandom);
      lut_sel    = 5'($urandom);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
